// File: rtl/ejtag_datain_pkg.sv
// Shared definitions for the EJTAG data register path: write target codes,
// sticky error bit positions and the data-in FSM state encoding.
package ejtag_datain_pkg;

  // Write target codes carried on EJDI_WR_SEL. NONE never appears with valid.
  typedef enum logic [2:0] {
    WR_SEL_NONE = 3'd0,
    WR_SEL_DCR  = 3'd1,
    WR_SEL_INST = 3'd2,
    WR_SEL_DATA = 3'd3,
    WR_SEL_PROC = 3'd4
  } wr_sel_e;

  // Bit positions inside the sticky EJDI_ERR vector {timeout, overrun, short}.
  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_SHORT   = 0;
  localparam int unsigned ERR_OVERRUN = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

  // Data-in controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRITE = 2'd2
  } dr_state_e;

  // Resolve the active DR select groups to one target. The order matches
  // the data-out mux: DCR wins, then instruction, then data, then processor.
  function automatic wr_sel_e wr_sel_from_groups(input logic dcr,
                                                 input logic inst,
                                                 input logic data,
                                                 input logic proc);
    wr_sel_e sel;
    sel = WR_SEL_NONE;
    if (dcr) begin
      sel = WR_SEL_DCR;
    end else if (inst) begin
      sel = WR_SEL_INST;
    end else if (data) begin
      sel = WR_SEL_DATA;
    end else if (proc) begin
      sel = WR_SEL_PROC;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ejtag_datain_shifter.sv
// Serial data register: parallel capture, LSB-first shift with TDI entering
// at the top, and a saturating count of bits shifted since the last capture.
module ejtag_dr_shifter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              capture_i,
  input  logic              shift_i,
  input  logic              tdi_i,
  input  logic [DATA_W-1:0] capture_data_i,
  output logic [DATA_W-1:0] sr_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              tdo_o
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Capture takes priority over a shift arriving in the same cycle.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (capture_i) begin
      sr_d  = capture_data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d = {tdi_i, sr_q[DATA_W-1:1]};
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr_o  = sr_q;
  assign cnt_o = cnt_q;
  assign tdo_o = sr_q[0];

endmodule

// File: rtl/ejtag_datain.sv
// Host-to-core EJTAG data register: shifts the DR serially and, on Update-DR
// with a full word, issues one write toward the selected target.
//
// Write handshake: EJDI_WR_VALID is high for every cycle the FSM is in WRITE;
// EJDI_WR_SEL and EJDI_WR_DATA are held constant for that whole time. A write
// completes on the first rising edge where valid and EJDI_WR_ACK are both
// high (ack in the first valid cycle is legal); valid drops the next cycle.
// Ack while valid is low is ignored. If no ack arrives within ACK_TIMEOUT
// valid cycles the write is abandoned and the timeout error is raised.
module ejtag_datain
  import ejtag_datain_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              CORE_CLOCK,
  input  logic              RESET_D1_R_N,
  input  logic              EJTAP_CAPTURE,
  input  logic              EJTAP_SHIFT,
  input  logic              EJTAP_UPDATE,
  input  logic              EJTAP_TDI,
  input  logic [DATA_W-1:0] EJDO_DATA,
  input  logic              EJDI_SELDCR,
  input  logic              EJDI_SELIBS,
  input  logic              EJDI_SELDBS,
  input  logic              EJDI_SELPBS,
  input  logic              EJDI_SELIBRS,
  input  logic              EJDI_SELDBRS,
  input  logic              EJDI_SELPBRS,
  input  logic              EJDI_WR_ACK,
  output logic              EJDI_TDO,
  output logic              EJDI_WR_VALID,
  output logic [2:0]        EJDI_WR_SEL,
  output logic [DATA_W-1:0] EJDI_WR_DATA,
  output logic              EJDI_BUSY,
  output logic [ERR_W-1:0]  EJDI_ERR,
  output dr_state_e         EJDI_DBG_STATE
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  // Timer counts valid cycles from 0; the last allowed cycle is ACK_TIMEOUT-1.
  localparam logic [7:0]       TMR_LAST = 8'(ACK_TIMEOUT - 1);

  dr_state_e         state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  wr_sel_e           wr_sel_q, wr_sel_d;

  logic              in_write;
  logic              any_strobe;
  logic              sh_capture;
  logic              sh_shift;
  logic              upd_take;
  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;
  logic              grp_dcr, grp_inst, grp_data, grp_proc;
  wr_sel_e           sel_code;

  assign in_write   = (state_q == ST_WRITE);
  assign any_strobe = EJTAP_CAPTURE | EJTAP_SHIFT | EJTAP_UPDATE;

  // While a write is outstanding the shift register is frozen so the word
  // being written cannot be disturbed by late TAP activity.
  assign sh_capture = EJTAP_CAPTURE & ~in_write;
  assign sh_shift   = EJTAP_SHIFT & ~in_write;
  // Capture in the same cycle as Update wins; the Update is dropped.
  assign upd_take   = EJTAP_UPDATE & ~EJTAP_CAPTURE & ~in_write;

  // Select groups: IBS/IBRS, DBS/DBRS and PBS/PBRS each share one target.
  assign grp_dcr  = EJDI_SELDCR;
  assign grp_inst = EJDI_SELIBS | EJDI_SELIBRS;
  assign grp_data = EJDI_SELDBS | EJDI_SELDBRS;
  assign grp_proc = EJDI_SELPBS | EJDI_SELPBRS;
  assign sel_code = wr_sel_from_groups(grp_dcr, grp_inst, grp_data, grp_proc);

  ejtag_dr_shifter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shifter (
    .clk_i          (CORE_CLOCK),
    .rst_ni         (RESET_D1_R_N),
    .capture_i      (sh_capture),
    .shift_i        (sh_shift),
    .tdi_i          (EJTAP_TDI),
    .capture_data_i (EJDO_DATA),
    .sr_o           (sr),
    .cnt_o          (cnt),
    .tdo_o          (EJDI_TDO)
  );

  // Next-state, error and write-latch logic for the controller.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    err_d     = err_q;
    wr_data_d = wr_data_q;
    wr_sel_d  = wr_sel_q;
    unique case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (EJTAP_CAPTURE) begin
          err_d   = '0;
          state_d = ST_SHIFT;
        end else if (upd_take) begin
          // Update without a preceding Capture behaves like Update in SHIFT.
          state_d = ST_IDLE;
          if (cnt != CNT_FULL) begin
            err_d[ERR_SHORT] = 1'b1;
          end else if (sel_code != WR_SEL_NONE) begin
            wr_data_d = sr;
            wr_sel_d  = sel_code;
            timer_d   = '0;
            state_d   = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (any_strobe) begin
          err_d[ERR_OVERRUN] = 1'b1;
        end
        if (EJDI_WR_ACK) begin
          state_d = ST_IDLE;
        end else if (timer_q == TMR_LAST) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state registers; reset drops valid asynchronously.
  always_ff @(posedge CORE_CLOCK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      err_q     <= '0;
      wr_data_q <= '0;
      wr_sel_q  <= WR_SEL_NONE;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      wr_data_q <= wr_data_d;
      wr_sel_q  <= wr_sel_d;
    end
  end

  assign EJDI_WR_VALID  = in_write;
  assign EJDI_WR_SEL    = wr_sel_q;
  assign EJDI_WR_DATA   = wr_data_q;
  assign EJDI_BUSY      = (state_q != ST_IDLE);
  assign EJDI_ERR       = err_q;
  assign EJDI_DBG_STATE = state_q;

`ifndef SYNTHESIS
  // Simulation aid: several select groups at Update points at a decode bug
  // upstream; the priority order still picks one target.
  always @(posedge CORE_CLOCK) begin
    if (RESET_D1_R_N && upd_take &&
        ($countones({grp_dcr, grp_inst, grp_data, grp_proc}) > 1)) begin
      $display("ejtag_datain: %0t more than one DR select group active at Update (groups dcr/inst/data/proc = %b)",
               $time, {grp_dcr, grp_inst, grp_data, grp_proc});
    end
  end
`endif

endmodule

// File: tb/tb_ejtag_datain.sv
// Randomized bench for ejtag_datain with a transaction-level reference model.
module tb_ejtag_datain;
  import ejtag_datain_pkg::*;

  localparam int DATA_W      = 32;
  localparam int ACK_TIMEOUT = 15;

  // select vector order: {DCR, IBS, DBS, PBS, IBRS, DBRS, PBRS}
  localparam logic [6:0] SEL_DCR  = 7'b1000000;
  localparam logic [6:0] SEL_IBS  = 7'b0100000;
  localparam logic [6:0] SEL_DBS  = 7'b0010000;
  localparam logic [6:0] SEL_PBS  = 7'b0001000;
  localparam logic [6:0] SEL_IBRS = 7'b0000100;
  localparam logic [6:0] SEL_PBRS = 7'b0000001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cap = 1'b0, sh = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic [DATA_W-1:0] do_data = '0;
  logic              s_dcr = 0, s_ibs = 0, s_dbs = 0, s_pbs = 0;
  logic              s_ibrs = 0, s_dbrs = 0, s_pbrs = 0;
  logic              ack = 1'b0;
  logic              tdo, wr_valid, busy;
  logic [2:0]        wr_sel, err;
  logic [DATA_W-1:0] wr_data;
  dr_state_e         dbg_state;

  ejtag_datain #(.DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .CORE_CLOCK     (clk),
    .RESET_D1_R_N   (rst_n),
    .EJTAP_CAPTURE  (cap),
    .EJTAP_SHIFT    (sh),
    .EJTAP_UPDATE   (upd),
    .EJTAP_TDI      (tdi),
    .EJDO_DATA      (do_data),
    .EJDI_SELDCR    (s_dcr),
    .EJDI_SELIBS    (s_ibs),
    .EJDI_SELDBS    (s_dbs),
    .EJDI_SELPBS    (s_pbs),
    .EJDI_SELIBRS   (s_ibrs),
    .EJDI_SELDBRS   (s_dbrs),
    .EJDI_SELPBRS   (s_pbrs),
    .EJDI_WR_ACK    (ack),
    .EJDI_TDO       (tdo),
    .EJDI_WR_VALID  (wr_valid),
    .EJDI_WR_SEL    (wr_sel),
    .EJDI_WR_DATA   (wr_data),
    .EJDI_BUSY      (busy),
    .EJDI_ERR       (err),
    .EJDI_DBG_STATE (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [34:0] exp_q[$];   // expected writes {sel, data}

  logic [DATA_W-1:0] m_sr;
  int                m_cnt;
  logic [2:0]        m_err;
  logic              m_busy;
  logic [2:0]        obs_sel;
  logic [DATA_W-1:0] obs_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_code(input logic [6:0] s);
    if (s[6])             return 3'd1;
    if (s[5] | s[2])      return 3'd2;
    if (s[4] | s[1])      return 3'd3;
    if (s[3] | s[0])      return 3'd4;
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_sr = '0; m_cnt = 0; m_err = '0; m_busy = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [6:0] s);
    {s_dcr, s_ibs, s_dbs, s_pbs, s_ibrs, s_dbrs, s_pbrs} = s;
  endtask

  task automatic capture(input logic [DATA_W-1:0] d);
    do_data = d; cap = 1'b1;
    tick();
    cap = 1'b0;
    m_sr = d; m_cnt = 0; m_err = '0; m_busy = 1'b1;
    check_eq("tdo_cap", tdo, m_sr[0]);
    check_eq("err_cap", err, m_err);
    check_eq("busy_cap", busy, m_busy);
  endtask

  task automatic shift(input logic b);
    tdi = b; sh = 1'b1;
    tick();
    sh = 1'b0;
    m_sr  = (m_sr >> 1) | (DATA_W'(b) << (DATA_W - 1));
    m_cnt = (m_cnt < DATA_W) ? m_cnt + 1 : DATA_W;
    check_eq("tdo_shift", tdo, m_sr[0]);
  endtask

  task automatic shift_word(input logic [DATA_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) shift(w[i % DATA_W]);
  endtask

  // Pulse Update, then serve the resulting write (if any): ack in valid
  // cycle ack_at (0 or >ACK_TIMEOUT: never), optional stray strobe in
  // valid cycle ovr_at of kind ovr_kind (0 cap, 1 shift, 2 update).
  task automatic update_and_serve(input logic [6:0] s, input int ack_at,
                                  input int ovr_at, input int ovr_kind);
    logic [2:0]  code;
    logic        want_write;
    int          exp_len;
    int          nvalid;
    logic [34:0] exp_w;
    code = exp_code(s);
    want_write = (m_cnt == DATA_W) && (code != 3'd0);
    set_sel(s); upd = 1'b1;
    tick();
    upd = 1'b0; set_sel(7'd0);
    if (m_cnt != DATA_W) m_err[0] = 1'b1;
    m_busy = 1'b0;
    exp_len = 0;
    if (want_write) begin
      exp_q.push_back({code, m_sr});
      if (ack_at >= 1 && ack_at <= ACK_TIMEOUT) exp_len = ack_at;
      else begin
        exp_len = ACK_TIMEOUT;
        m_err[2] = 1'b1;
      end
      if (ovr_at >= 1 && ovr_at <= exp_len) m_err[1] = 1'b1;
    end
    nvalid = 0;
    exp_w  = '0;
    for (int c = 0; c < 40; c++) begin
      if (!wr_valid) break;
      nvalid++;
      if (nvalid == 1) begin
        if (exp_q.size() != 0) exp_w = exp_q.pop_front();
        check_eq("wr_sel", wr_sel, exp_w[34:32]);
        check_eq("wr_data", wr_data, exp_w[31:0]);
        obs_sel = wr_sel; obs_data = wr_data;
      end else begin
        check_eq("wr_hold", {wr_sel, wr_data}, exp_w);
      end
      check_eq("busy_write", busy, 1'b1);
      ack = (nvalid == ack_at);
      if (nvalid == ovr_at) begin
        case (ovr_kind)
          0:       cap = 1'b1;
          1:       sh  = 1'b1;
          default: upd = 1'b1;
        endcase
      end
      tick();
      ack = 1'b0; cap = 1'b0; sh = 1'b0; upd = 1'b0;
    end
    check_eq("valid_cycles", nvalid, exp_len);
    check_eq("write_seen", exp_q.size(), 0);
    exp_q.delete();
    if (ack_at == ACK_TIMEOUT + 1) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_eq("stray_ack_valid", wr_valid, 1'b0);
    end
    check_eq("err_upd", err, m_err);
    check_eq("busy_upd", busy, m_busy);
    check_eq("tdo_upd", tdo, m_sr[0]);
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] seq;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tdo", tdo, 1'b0);
    check_eq("rst_valid", wr_valid, 1'b0);
    check_eq("rst_sel", wr_sel, 3'd0);
    check_eq("rst_data", wr_data, 32'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err, 3'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Capture and shift out LSB first.
    capture(32'hA5A5_0F0F);
    seq = '0;
    seq[0] = tdo;
    for (int i = 1; i < DATA_W; i++) begin
      shift(1'b0);
      seq[i] = tdo;
    end
    shift(1'b0);
    check_eq("tdo_pattern", seq, 32'hA5A5_0F0F);
    check_eq("tdo_after_32", tdo, 1'b0);

    // Full write to the data target, ack in the third valid cycle.
    capture(32'h0);
    shift_word(32'hDEAD_BEEF, 32);
    update_and_serve(SEL_DBS, 3, 0, 0);
    check_eq("dbs_sel", obs_sel, 3'd3);
    check_eq("dbs_data", obs_data, 32'hDEAD_BEEF);

    // Short shift: no write, short error.
    capture(32'h1111_2222);
    shift_word(32'h5555_AAAA, 31);
    update_and_serve(SEL_DCR, 1, 0, 0);
    check_eq("short_err", err, 3'b001);

    // Two select groups: DCR wins.
    capture(32'h0);
    shift_word(32'h1357_9BDF, 32);
    update_and_serve(SEL_DCR | SEL_PBS, 1, 0, 0);
    check_eq("multi_sel", obs_sel, 3'd1);

    // Timeout, then timeout with an overrun capture during the wait.
    capture(32'h0);
    shift_word(32'hCAFE_F00D, 32);
    update_and_serve(SEL_PBRS, 0, 0, 0);
    check_eq("timeout_err", err, 3'b100);
    capture(32'h0);
    shift_word(32'h0F1E_2D3C, 32);
    update_and_serve(SEL_IBRS, 0, 5, 0);
    check_eq("overrun_err", err, 3'b110);

    // Reset in the second WRITE cycle.
    capture(32'h0);
    shift_word(32'h0BAD_F00D, 32);
    set_sel(SEL_DBS); upd = 1'b1;
    tick();
    upd = 1'b0; set_sel(7'd0);
    check_eq("pre_rst_valid", wr_valid, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", wr_valid, 1'b0);
    check_eq("mid_rst_sel", wr_sel, 3'd0);
    check_eq("mid_rst_data", wr_data, 32'd0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_err", err, 3'd0);
    check_eq("mid_rst_tdo", tdo, 1'b0);
    model_reset();
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    tick();
    capture(32'h1234_5679);
    shift_word(32'h89AB_CDEF, 32);
    update_and_serve(SEL_IBS, 2, 0, 0);
    check_eq("post_rst_sel", obs_sel, 3'd2);
    check_eq("post_rst_data", obs_data, 32'h89AB_CDEF);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      logic [6:0] s;
      int n, r, ack_at, ovr_at;
      if ($urandom_range(0, 4) != 0) capture($urandom);
      n = ($urandom_range(0, 9) < 7) ? 32 : $urandom_range(0, 40);
      shift_word($urandom, n);
      r = $urandom_range(0, 9);
      if (r == 0)      s = 7'd0;
      else if (r == 1) s = 7'($urandom_range(0, 127));
      else             s = 7'(1 << $urandom_range(0, 6));
      ack_at = $urandom_range(0, ACK_TIMEOUT + 2);
      ovr_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
      update_and_serve(s, ack_at, ovr_at, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_bad);
    $fatal(1);
  end

endmodule
